// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM: per-state datapath controls, a memory-ready
// handshake, a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_control #(
    parameter int RETIRE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              opcode,
    input  logic                    memReady,
    output logic                    pcWrite,
    output logic                    pcWriteCond,
    output logic                    instrOrData,
    output logic                    memReadEnable,
    output logic                    enableWriteToDataMemory,
    output logic                    irWrite,
    output logic                    writeRegFromMem,
    output logic                    writeRegAddressSource,
    output logic                    writeRegEnable,
    output logic                    aluSrcA,
    output logic [1:0]              aluSrcB,
    output logic [1:0]              aluInstruct,
    output logic [1:0]              pcSource,
    output logic [3:0]              state,
    output logic                    illegalOpcode,
    output logic [RETIRE_WIDTH-1:0] retiredCount
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t                  state_q, state_d;
    logic                    is_sw_q, is_sw_d;
    logic                    illegal_q, illegal_d;
    logic [RETIRE_WIDTH-1:0] retired_q;
    logic                    retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            is_sw_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            is_sw_q   <= is_sw_d;
            illegal_q <= illegal_d;
            retired_q <= retired_q + {{(RETIRE_WIDTH-1){1'b0}}, retire};
        end
    end

    always_comb begin
        state_d                 = S_FETCH;
        is_sw_d                 = is_sw_q;
        illegal_d               = illegal_q;
        retire                  = 1'b0;
        pcWrite                 = 1'b0;
        pcWriteCond             = 1'b0;
        instrOrData             = 1'b0;
        memReadEnable           = 1'b0;
        enableWriteToDataMemory = 1'b0;
        irWrite                 = 1'b0;
        writeRegFromMem         = 1'b0;
        writeRegAddressSource   = 1'b0;
        writeRegEnable          = 1'b0;
        aluSrcA                 = 1'b0;
        aluSrcB                 = 2'b00;
        aluInstruct             = 2'b00;
        pcSource                = 2'b00;
        case (state_q)
            S_FETCH: begin
                memReadEnable = 1'b1;
                aluSrcB       = 2'b01;
                irWrite       = memReady;
                pcWrite       = memReady;
                state_d       = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_R:    state_d = S_EXECUTE;
                    OP_LW: begin
                        state_d = S_MEMADR;
                        is_sw_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d = S_MEMADR;
                        is_sw_d = 1'b1;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = is_sw_q ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                memReadEnable = 1'b1;
                instrOrData   = 1'b1;
                state_d       = memReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                writeRegEnable  = 1'b1;
                writeRegFromMem = 1'b1;
                retire          = 1'b1;
            end
            S_MEMWRITE: begin
                enableWriteToDataMemory = 1'b1;
                instrOrData             = 1'b1;
                retire                  = memReady;
                state_d = memReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                aluSrcA     = 1'b1;
                aluInstruct = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                writeRegEnable        = 1'b1;
                writeRegAddressSource = 1'b1;
                retire                = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluInstruct = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                retire      = 1'b1;
            end
            S_ADDIEX: begin
                aluSrcA     = 1'b1;
                aluSrcB     = 2'b10;
                aluInstruct = 2'b11;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                writeRegEnable = 1'b1;
                retire         = 1'b1;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
                retire   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset abandons the instruction: no write, no retire, no memory access.
        if (reset) begin
            pcWrite                 = 1'b0;
            pcWriteCond             = 1'b0;
            irWrite                 = 1'b0;
            writeRegEnable          = 1'b0;
            memReadEnable           = 1'b0;
            enableWriteToDataMemory = 1'b0;
            retire                  = 1'b0;
        end
    end

    assign state         = state_q;
    assign illegalOpcode = illegal_q;
    assign retiredCount  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle state/control
// entries are queued with the stimulus and compared as the FSM steps.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        memReady = 1'b0;

    logic        pcWrite, pcWriteCond, instrOrData, memReadEnable;
    logic        enableWriteToDataMemory, irWrite, writeRegFromMem;
    logic        writeRegAddressSource, writeRegEnable, aluSrcA;
    logic [1:0]  aluSrcB, aluInstruct, pcSource;
    logic [3:0]  state;
    logic        illegalOpcode;
    logic [31:0] retiredCount;

    logic        pcWrite4, pcWriteCond4, instrOrData4, memReadEnable4;
    logic        enableWriteToDataMemory4, irWrite4, writeRegFromMem4;
    logic        writeRegAddressSource4, writeRegEnable4, aluSrcA4;
    logic [1:0]  aluSrcB4, aluInstruct4, pcSource4;
    logic [3:0]  state4;
    logic        illegalOpcode4;
    logic [3:0]  retiredCount4;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
        .instrOrData(instrOrData), .memReadEnable(memReadEnable),
        .enableWriteToDataMemory(enableWriteToDataMemory),
        .irWrite(irWrite), .writeRegFromMem(writeRegFromMem),
        .writeRegAddressSource(writeRegAddressSource),
        .writeRegEnable(writeRegEnable), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluInstruct(aluInstruct),
        .pcSource(pcSource), .state(state),
        .illegalOpcode(illegalOpcode), .retiredCount(retiredCount)
    );

    multicycle_control #(.RETIRE_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite4), .pcWriteCond(pcWriteCond4),
        .instrOrData(instrOrData4), .memReadEnable(memReadEnable4),
        .enableWriteToDataMemory(enableWriteToDataMemory4),
        .irWrite(irWrite4), .writeRegFromMem(writeRegFromMem4),
        .writeRegAddressSource(writeRegAddressSource4),
        .writeRegEnable(writeRegEnable4), .aluSrcA(aluSrcA4),
        .aluSrcB(aluSrcB4), .aluInstruct(aluInstruct4),
        .pcSource(pcSource4), .state(state4),
        .illegalOpcode(illegalOpcode4), .retiredCount(retiredCount4)
    );

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3;
    localparam int MEMWB = 4, MEMWRITE = 5, EXECUTE = 6, ALUWB = 7;
    localparam int BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
    // pcWrite, pcWriteCond, memRead, memWrite, irWrite, writeRegEnable
    localparam logic [15:0] EN_MASK = 16'hDC80;

    typedef struct {
        int         st;
        bit         mr;
        logic [5:0] op;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] ret_exp = 32'd0;
    logic        ill_exp = 1'b0;
    logic [15:0] act;

    assign act = {pcWrite, pcWriteCond, instrOrData, memReadEnable,
                  enableWriteToDataMemory, irWrite, writeRegFromMem,
                  writeRegAddressSource, writeRegEnable, aluSrcA,
                  aluSrcB, aluInstruct, pcSource};

    function automatic logic [15:0] exp_ctl(int st, bit mr);
        logic pw, pwc, iod, mrd, mwr, irw, wfm, was, wen, sa;
        logic [1:0] sb, ai, ps;
        {pw, pwc, iod, mrd, mwr, irw, wfm, was, wen, sa} = '0;
        sb = 2'b00; ai = 2'b00; ps = 2'b00;
        case (st)
            FETCH:    begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
            DECODE:   sb = 2'b11;
            MEMADR:   begin sa = 1; sb = 2'b10; end
            MEMREAD:  begin mrd = 1; iod = 1; end
            MEMWB:    begin wen = 1; wfm = 1; end
            MEMWRITE: begin mwr = 1; iod = 1; end
            EXECUTE:  begin sa = 1; ai = 2'b10; end
            ALUWB:    begin wen = 1; was = 1; end
            BRANCH:   begin sa = 1; ai = 2'b01; pwc = 1; ps = 2'b01; end
            ADDIEX:   begin sa = 1; sb = 2'b10; ai = 2'b11; end
            ADDIWB:   wen = 1;
            JUMP:     begin pw = 1; ps = 2'b10; end
            default:  ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, wfm, was, wen, sa, sb, ai, ps};
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    task automatic push(int st, bit mr, logic [5:0] op);
        exp_t e;
        e.st = st; e.mr = mr; e.op = op;
        q.push_back(e);
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    task automatic push_instr(logic [5:0] op, int fw, int mw);
        for (int i = 0; i < fw; i++) push(FETCH, 0, junk());
        push(FETCH, 1, junk());
        push(DECODE, rbit(), op);
        case (op)
            OP_R: begin
                push(EXECUTE, rbit(), junk());
                push(ALUWB, rbit(), junk());
            end
            OP_LW: begin
                push(MEMADR, rbit(), junk());
                for (int i = 0; i < mw; i++) push(MEMREAD, 0, junk());
                push(MEMREAD, 1, junk());
                push(MEMWB, rbit(), junk());
            end
            OP_SW: begin
                push(MEMADR, rbit(), junk());
                for (int i = 0; i < mw; i++) push(MEMWRITE, 0, junk());
                push(MEMWRITE, 1, junk());
            end
            OP_BEQ:  push(BRANCH, rbit(), junk());
            OP_ADDI: begin
                push(ADDIEX, rbit(), junk());
                push(ADDIWB, rbit(), junk());
            end
            OP_J:    push(JUMP, rbit(), junk());
            default: ;
        endcase
    endtask

    task automatic drain(string name);
        exp_t e;
        logic [15:0] ec;
        while (q.size() > 0) begin
            e = q.pop_front();
            memReady = e.mr;
            opcode = e.op;
            #1;
            ec = exp_ctl(e.st, e.mr);
            checks++;
            if (state !== 4'(e.st)) begin
                failures++;
                $display("FAIL %s state: got %0d want %0d", name, state, e.st);
            end
            checks++;
            if (act !== ec) begin
                failures++;
                $display("FAIL %s ctl st=%0d: got %h want %h", name, e.st, act, ec);
            end
            checks++;
            if (retiredCount !== ret_exp) begin
                failures++;
                $display("FAIL %s retired: got %0d want %0d", name, retiredCount, ret_exp);
            end
            checks++;
            if (retiredCount4 !== ret_exp[3:0]) begin
                failures++;
                $display("FAIL %s retired4: got %0d want %0d", name, retiredCount4, ret_exp[3:0]);
            end
            checks++;
            if (illegalOpcode !== ill_exp) begin
                failures++;
                $display("FAIL %s illegal: got %b want %b", name, illegalOpcode, ill_exp);
            end
            @(posedge clk);
            if (e.st == DECODE && !legal(e.op)) ill_exp = 1'b1;
            if (e.st inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP} ||
                (e.st == MEMWRITE && e.mr)) ret_exp = ret_exp + 32'd1;
            @(negedge clk);
        end
    endtask

    task automatic check_en_off(string name);
        checks++;
        if ((act & EN_MASK) !== 16'h0) begin
            failures++;
            $display("FAIL %s enables in reset: got %h want 0", name, act & EN_MASK);
        end
    endtask

    task automatic test_reset();
        memReady = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1 check_en_off("reset");
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        checks++;
        if (state !== 4'd0 || retiredCount !== 32'd0 || illegalOpcode !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got st=%0d ret=%0d ill=%b want 0 0 0",
                     state, retiredCount, illegalOpcode);
        end
        reset = 1'b0;
        ret_exp = 32'd0;
        ill_exp = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1 check_en_off("pulse_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ret_exp = 32'd0;
        ill_exp = 1'b0;
    endtask

    task automatic test_rtype();
        push_instr(OP_R, 0, 0);
        drain("rtype");
    endtask

    task automatic test_lw_wait();
        push_instr(OP_LW, 0, 3);
        drain("lw_wait");
    endtask

    task automatic test_back_to_back();
        push_instr(OP_SW, 0, 0);
        push_instr(OP_BEQ, 0, 0);
        push_instr(OP_J, 0, 0);
        push_instr(OP_ADDI, 0, 0);
        push_instr(OP_SW, 2, 2);
        push_instr(OP_LW, 1, 0);
        drain("back_to_back");
    endtask

    task automatic test_illegal();
        push_instr(6'h3f, 0, 0);
        push_instr(OP_R, 0, 0);
        push_instr(6'h11, 1, 0);
        push_instr(OP_ADDI, 0, 0);
        drain("illegal");
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int i = 0; i < 17; i++) push_instr(OP_J, 0, 0);
        drain("wrap");
        checks++;
        if (retiredCount4 !== 4'd1 || retiredCount !== 32'd17) begin
            failures++;
            $display("FAIL wrap_final: got %0d/%0d want 1/17", retiredCount4, retiredCount);
        end
    endtask

    task automatic test_reset_midwrite();
        push(FETCH, 1, junk());
        push(DECODE, 1, OP_SW);
        push(MEMADR, 1, junk());
        drain("midwrite_pre");
        memReady = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'(MEMWRITE) || enableWriteToDataMemory !== 1'b0) begin
            failures++;
            $display("FAIL midwrite_rst: got st=%0d wr=%b want 5 0",
                     state, enableWriteToDataMemory);
        end
        check_en_off("midwrite");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ret_exp = 32'd0;
        ill_exp = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || retiredCount !== 32'd0) begin
            failures++;
            $display("FAIL midwrite_after: got st=%0d ret=%0d want 0 0",
                     state, retiredCount);
        end
        push_instr(OP_R, 0, 0);
        drain("midwrite_post");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_illegal();
        test_wrap();
        test_reset_midwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencing FSM that drives the shared MIPS datapath over several cycles per instruction: one memory port, one ALU, IR/MDR/A/B/ALUOut registers.
- Supports R-type, addi, lw, sw, beq and j, using the same opcode encodings and aluInstruct codes as the single-cycle decoder.
- Adds a memory-ready handshake, a retired-instruction counter and a sticky illegal-opcode flag.
- Sits between the instruction register opcode field and the datapath mux/enable inputs; the ALU function controller is unchanged.

Parameters:
RETIRE_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instruction bits [31:26] from the IR
memReady  input  1  memory completes the current access this cycle
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if ALU zero (beq)
instrOrData  output  1  memory address source: 0 = PC, 1 = ALUOut
memReadEnable  output  1  memory read request
enableWriteToDataMemory  output  1  memory write request
irWrite  output  1  IR load
writeRegFromMem  output  1  register write data: 1 = MDR, 0 = ALUOut
writeRegAddressSource  output  1  1 = rd [15:11], 0 = rt [20:16]
writeRegEnable  output  1  register file write
aluSrcA  output  1  0 = PC, 1 = register A
aluSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
aluInstruct  output  2  00 = add, 01 = sub, 10 = R-type function field, 11 = addi
pcSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current state encoding (debug)
illegalOpcode  output  1  sticky; set on an unsupported opcode
retiredCount  output  RETIRE_WIDTH  number of completed instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, go to FETCH next cycle with all enables 0.
- Every output not listed for a state is 0. No X values are driven.
- FETCH:
  - Outputs: memReadEnable=1, aluSrcA=0, aluSrcB=01, aluInstruct=00, pcSource=00.
  - irWrite and pcWrite = memReady.
  - Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluInstruct=00 (branch target into ALUOut).
  - Next state by opcode: 000000 -> EXECUTE; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode: set illegalOpcode, go to FETCH, do not retire.
- MEMADR:
  - Outputs: aluSrcA=1, aluSrcB=10, aluInstruct=00.
  - Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD:
  - Outputs: memReadEnable=1, instrOrData=1.
  - Hold until memReady=1, then go to MEMWB.
- MEMWB:
  - Outputs: writeRegEnable=1, writeRegFromMem=1, writeRegAddressSource=0.
  - Retire; go to FETCH.
- MEMWRITE:
  - Outputs: enableWriteToDataMemory=1, instrOrData=1.
  - Hold until memReady=1; on that cycle retire and go to FETCH.
- EXECUTE:
  - Outputs: aluSrcA=1, aluSrcB=00, aluInstruct=10.
  - Go to ALUWB.
- ALUWB:
  - Outputs: writeRegEnable=1, writeRegFromMem=0, writeRegAddressSource=1.
  - Retire; go to FETCH.
- BRANCH:
  - Outputs: aluSrcA=1, aluSrcB=00, aluInstruct=01, pcWriteCond=1, pcSource=01.
  - Retire; go to FETCH.
- ADDIEX:
  - Outputs: aluSrcA=1, aluSrcB=10, aluInstruct=11.
  - Go to ADDIWB.
- ADDIWB:
  - Outputs: writeRegEnable=1, writeRegFromMem=0, writeRegAddressSource=0.
  - Retire; go to FETCH.
- JUMP:
  - Outputs: pcWrite=1, pcSource=10.
  - Retire; go to FETCH.
- Cycle counts with memReady held at 1: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each memReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- opcode is sampled only in DECODE. Changes in other states have no effect.
- retiredCount increments by 1 on each retire cycle and wraps from 2^RETIRE_WIDTH-1 to 0.
- Reset:
  - Synchronous. At the next clk edge: state=FETCH, retiredCount=0, illegalOpcode=0.
  - While reset is high, pcWrite, pcWriteCond, irWrite, writeRegEnable, memReadEnable and enableWriteToDataMemory are forced to 0 regardless of state.
  - Reset mid-instruction abandons it: no retire, no write.
- Reset takes priority over memReady and all state transitions.

Test Plan:
- reset=1 for 2 cycles, then release with memReady=1 -> state=0, retiredCount=0, illegalOpcode=0; first cycle after release shows pcWrite=1, irWrite=1, memReadEnable=1.
- opcode=000000, memReady=1 -> states 0,1,6,7,0; writeRegEnable=1 with writeRegAddressSource=1 only in ALUWB; retiredCount 0 -> 1.
- opcode=100011, memReady low for 3 cycles in MEMREAD -> 8 total cycles; instrOrData=1 throughout MEMREAD; writeRegFromMem=1 in MEMWB; retiredCount +1.
- Sequence sw, beq, j, addi with memReady=1 -> cycle counts 4, 3, 3, 4; pcWriteCond pulses once with aluInstruct=01; pcSource=10 in JUMP; retiredCount=4.
- opcode=111111 in DECODE -> illegalOpcode=1, back to FETCH, retiredCount unchanged; flag stays 1 through later legal instructions until reset.
- RETIRE_WIDTH=4, run 17 j instructions -> retiredCount wraps 15 -> 0 -> 1; reset asserted in MEMWRITE with memReady=0 -> enableWriteToDataMemory=0 that cycle, state=0 next cycle, no retire.
